relu_maxpool2x2_stream: RTL and testbench
=========================================

Name: relu_maxpool2x2_stream

Overview:
- Streaming post-processing stage directly downstream of the Conv2d feature-map output in the CRNN front end.
- Takes one output-channel map as signed fixed-point pixels in raster order and performs 2x2/stride-2 max-pooling, with optional ReLU.
- Emits pooled pixels in raster order over a valid/ready handshake to the next conv layer's input packer.
- Holds one half-width line buffer; never stores the full map.

Parameters:
- N, 24, pixel word width (signed two's complement, matches Conv2d N).
- Q, 13, fractional bits; carried through untouched, used only for documentation/bench scaling.
- W, 42, input map width in pixels (Conv2d output width w-2+2p); W>=2.
- H, 4, input map height in pixels; H>=2.

Ports:
- clk  in  1  rising-edge clock.
- global_rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  N  signed input pixel, raster order, row-major.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  N  signed pooled pixel.
- out_last  out  1  qualifies the final pooled pixel of a map.
- frame_done  out  1  one-cycle pulse after the last input pixel (row H-1, col W-1) is accepted.

Behaviour:
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, frame_done=0; col/row counters=0; hold register and line buffer contents don't-care (never read before written). Reset mid-frame discards the partial frame; the next accepted pixel is treated as row 0 col 0.
- Counters:
  - col advances 0..W-1 per input transfer, then wraps to 0 and row increments.
  - row wraps 0..H-1.
  - At wrap of both, frame_done pulses for 1 cycle.
- Pool geometry:
  - PW=floor(W/2), PH=floor(H/2).
  - Odd trailing column (col=W-1 when W odd) and odd trailing row (row=H-1 when H odd) are accepted and discarded; no output is produced for them.
- Pooling datapath (all compares signed N-bit, no widening, no rounding):
  - Even col within pooled range: load hold register with in_data.
  - Even row, odd col: linebuf[col>>1] <= max(hold, in_data).
  - Odd row, odd col: out_data <= max(linebuf[col>>1], hold, in_data); out_valid <= 1.
  - out_last <= 1 when row=2*PH-1 and col=2*PW-1.
- Latency: out_valid rises the cycle after the input transfer that completes a 2x2 window (1-cycle latency).
- Output register is single-entry:
  - in_ready = !out_valid | out_ready, combinational; backpressure stalls the input, and no pixel is ever dropped.
  - When an output transfer occurs and no new window completes that cycle, out_valid <= 0 and out_last <= 0.
  - An output transfer and a new window completion in the same cycle load the new value with out_valid held at 1.
- out_data/out_last hold stable while out_valid & !out_ready.
- Ties return the shared value. Max of equal-magnitude negatives is exact.
- Consecutive maps stream back-to-back with no idle cycle required.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: each in_data is clamped to 0 if its sign bit is set before entering the hold/max logic, so out_data >= 0 always (ReLU folded before pool; equivalent to pool-then-ReLU).
- Undefined: pure signed max-pool; negative pooled results are passed through.

Test Plan:
- W=4, H=4, in_data=0..15 raster (value k<<13), out_ready=1 -> outputs 5,7,13,15 (<<13) at 1-cycle latency; out_last on 4th; frame_done 1 cycle after pixel 15.
- Same map with all values negated, macro undefined -> outputs -0,-2,-8,-10 (i.e. 0,-2<<13,-8<<13,-10<<13); macro defined -> all four outputs 0.
- Backpressure: out_ready toggled 1-of-3 cycles, in_valid always 1 -> in_ready low while output pending; output sequence identical to scenario 1; no loss or duplication; out_data stable while stalled.
- W=5, H=5, ramp 0..24 -> 4 outputs 6,8,16,18; column 4 and row 4 accepted but produce nothing; frame_done after pixel 24.
- Assert global_rst after 6 pixels of a 4x4 map, then send a full fresh 4x4 ramp -> outputs exactly 5,7,13,15, no stale output from the aborted frame; all outputs 0 during reset.
- Two 4x4 frames back-to-back with no gap -> 8 outputs; out_last on outputs 4 and 8 only.

Source files
------------

// File: rtl/relu_maxpool2x2_stream.sv
// relu_maxpool2x2_stream
//   Streaming 2x2 / stride-2 max-pool stage for one Conv2d output-channel map.
//   Pixels arrive in raster order and pooled pixels leave in raster order.
//   Storage is one hold register plus one half-width line buffer holding the
//   pairwise maxima of the even row. The full map is never stored.
//
//   Optional build macro POOL_RELU_EN: when defined, every negative input
//   pixel is clamped to 0 before pooling, so all outputs are >= 0.
//   Undefined (default): pure signed max-pool.
//
// Parameters
//   N  pixel word width, signed two's complement
//   Q  fractional bits; carried through untouched
//   W  input map width  (>= 2)
//   H  input map height (>= 2)
//
// Ports
//   clk         rising-edge clock
//   global_rst  asynchronous active-high reset
//   in_valid    input pixel valid
//   in_ready    block can accept in_data this cycle
//   in_data     signed input pixel, raster order
//   out_valid   pooled pixel valid
//   out_ready   downstream accepts out_data
//   out_data    signed pooled pixel
//   out_last    marks the final pooled pixel of a map
//   frame_done  one-cycle pulse after the last input pixel is accepted
module relu_maxpool2x2_stream #(
   parameter int N = 24,
   parameter int Q = 13,
   parameter int W = 42,
   parameter int H = 4
) (
   input  logic         clk,
   input  logic         global_rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last,
   output logic         frame_done
);

   localparam int PW  = W / 2;
   localparam int PH  = H / 2;
   localparam int CW  = $clog2(W);
   localparam int RW  = $clog2(H);
   localparam int PCW = (PW > 1) ? $clog2(PW) : 1;

   localparam logic [CW-1:0] COL_LAST      = CW'(W - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(H - 1);
   localparam logic [CW-1:0] COL_POOL_LAST = CW'(2 * PW - 1);
   localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * PH - 1);

   if (W < 2 || H < 2 || Q >= N) begin : g_bad_params
      $error("relu_maxpool2x2_stream: need W>=2, H>=2, Q<N");
   end

   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic [N-1:0]   hold;
   logic [N-1:0]   linebuf [PW];
   logic [N-1:0]   pix;
   logic [PCW-1:0] lb_idx;
   logic           xfer_in;
   logic           in_window;
   logic           window_done;
   logic [N-1:0]   pair_max;
   logic [N-1:0]   pooled;

   function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

`ifdef POOL_RELU_EN
   assign pix = in_data[N-1] ? '0 : in_data;
`else
   assign pix = in_data;
`endif

   // The single-entry output register frees up in the same cycle it drains,
   // so a completing window can never overwrite an unconsumed result.
   assign in_ready    = !out_valid || out_ready;
   assign xfer_in     = in_valid && in_ready;

   // Trailing odd column/row falls outside the window and is dropped.
   assign in_window   = (col <= COL_POOL_LAST) && (row <= ROW_POOL_LAST);
   assign window_done = xfer_in && in_window && col[0] && row[0];

   assign lb_idx      = PCW'(col >> 1);
   assign pair_max    = smax(hold, pix);
   assign pooled      = smax(linebuf[lb_idx], pair_max);

   // Hold register and line buffer are always written before being read
   // within a frame, so they need no reset.
   always_ff @(posedge clk) begin
      if (xfer_in && in_window) begin
         if (!col[0]) begin
            hold <= pix;
         end else if (!row[0]) begin
            linebuf[lb_idx] <= pair_max;
         end
      end
   end

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         col        <= '0;
         row        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         if (xfer_in) begin
            if (col == COL_LAST) begin
               col <= '0;
               if (row == ROW_LAST) begin
                  row        <= '0;
                  frame_done <= 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end

         // Overrides the drain above when a new window lands in the same cycle.
         if (window_done) begin
            out_data  <= pooled;
            out_valid <= 1'b1;
            out_last  <= (row == ROW_POOL_LAST) && (col == COL_POOL_LAST);
         end
      end
   end

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
module tb_relu_maxpool2x2_stream;

   localparam int N = 24;

   logic         clk = 1'b0;
   logic         global_rst;
   logic         in_valid;
   logic         out_ready;
   logic         sel;
   logic [N-1:0] in_data;

   logic         ir4, ov4, ol4, fd4, ir5, ov5, ol5, fd5;
   logic [N-1:0] od4, od5;
   logic         ir, ov, ol, fd;
   logic [N-1:0] od;

   assign ir = sel ? ir5 : ir4;
   assign ov = sel ? ov5 : ov4;
   assign ol = sel ? ol5 : ol4;
   assign fd = sel ? fd5 : fd4;
   assign od = sel ? od5 : od4;

   always #5 clk = ~clk;

   relu_maxpool2x2_stream #(.N(N), .Q(13), .W(4), .H(4)) dut4 (
      .clk(clk), .global_rst(global_rst), .in_valid(in_valid & ~sel), .in_ready(ir4),
      .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
      .out_last(ol4), .frame_done(fd4));

   relu_maxpool2x2_stream #(.N(N), .Q(13), .W(5), .H(5)) dut5 (
      .clk(clk), .global_rst(global_rst), .in_valid(in_valid & sel), .in_ready(ir5),
      .in_data(in_data), .out_valid(ov5), .out_ready(out_ready), .out_data(od5),
      .out_last(ol5), .frame_done(fd5));

   int           stim[$];
   int           exp_data[$];
   bit           exp_last[$];
   int           exp_idx[$];
   logic [N-1:0] got_data[$];
   bit           got_last[$];
   int           got_cyc[$];
   int           in_cyc[$];
   int           fd_cyc[$];
   int           viol_ready, viol_stable;
   bit           saw_stall, timed_out;
   int           checks = 0;
   int           passed = 0;

   function automatic int relu(input int v);
`ifdef POOL_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   // Reference: per pooled position, max over its four source pixels.
   task automatic build_model(input int w, input int h, input int nf);
      int base, m, v;
      exp_data.delete(); exp_last.delete(); exp_idx.delete();
      for (int f = 0; f < nf; f++) begin
         base = f * w * h;
         for (int pr = 0; pr < h / 2; pr++)
            for (int pc = 0; pc < w / 2; pc++) begin
               m = relu(stim[base + 2*pr*w + 2*pc]);
               for (int d = 1; d < 4; d++) begin
                  v = relu(stim[base + (2*pr + d/2)*w + 2*pc + d%2]);
                  if (v > m) m = v;
               end
               exp_data.push_back(m);
               exp_last.push_back(pr == h/2 - 1 && pc == w/2 - 1);
               exp_idx.push_back(base + (2*pr + 1)*w + 2*pc + 1);
            end
      end
   endtask

   task automatic fill_ramp(input int npix, input bit neg);
      stim.delete();
      for (int k = 0; k < npix; k++) stim.push_back(neg ? -(k << 13) : (k << 13));
   endtask

   task automatic do_reset();
      global_rst = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_data    = '0;
      repeat (2) @(negedge clk);
      global_rst = 1'b0;
      @(negedge clk);
   endtask

   // Drives stim[0..npix-1] and records everything observed; no checking.
   // rmode: 0 always ready, 1 ready 1-of-3, 2 random, 3 never ready.
   task automatic run_stream(input int npix, input int rmode);
      int           sent, cyc, idle, budget, tmp;
      bit           pstall;
      logic [N-1:0] pdata;
      bit           plast;
      sent = 0; cyc = 0; idle = 0; budget = 20 * npix + 40;
      pstall = 0; pdata = '0; plast = 0;
      got_data.delete(); got_last.delete(); got_cyc.delete();
      in_cyc.delete(); fd_cyc.delete();
      viol_ready = 0; viol_stable = 0; saw_stall = 0; timed_out = 0;
      while (!(sent == npix && idle >= 6) && cyc < budget) begin
         @(negedge clk);
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 3 == 0);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
         if (sent < npix) begin
            tmp      = stim[sent];
            in_valid = 1'b1;
            in_data  = tmp[N-1:0];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (ir !== (!ov || out_ready)) viol_ready++;
         if (ir === 1'b0) saw_stall = 1;
         if (pstall && (ov !== 1'b1 || od !== pdata || ol !== plast)) viol_stable++;
         if (fd === 1'b1) fd_cyc.push_back(cyc);
         if (ov && out_ready) begin
            got_data.push_back(od);
            got_last.push_back(ol);
            got_cyc.push_back(cyc);
         end
         pstall = ov && !out_ready;
         pdata  = od;
         plast  = ol;
         if (in_valid && ir) begin
            in_cyc.push_back(cyc);
            sent++;
         end
         if (sent == npix) idle++;
         cyc++;
      end
      timed_out = (cyc >= budget);
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      sel = 0;
      do_reset();
      checks++; if (ov !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", ov); else passed++;
      checks++; if (od !== '0) $display("FAIL reset_out_data: got %h exp 0", od); else passed++;
      checks++; if (ol !== 1'b0) $display("FAIL reset_out_last: got %b exp 0", ol); else passed++;
      checks++; if (fd !== 1'b0) $display("FAIL reset_frame_done: got %b exp 0", fd); else passed++;
      checks++; if (ir !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", ir); else passed++;
   endtask

   task automatic test_ramp();
      int ev;
      sel = 0;
      do_reset();
      fill_ramp(16, 0);
      build_model(4, 4, 1);
      run_stream(16, 0);
      checks++; if (timed_out) $display("FAIL ramp_timeout: got timeout exp completion"); else passed++;
      checks++; if (got_data.size() != 4) $display("FAIL ramp_count: got %0d exp 4", got_data.size()); else passed++;
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         ev = exp_data[k];
         checks++; if (got_data[k] !== ev[N-1:0]) $display("FAIL ramp_data[%0d]: got %h exp %h", k, got_data[k], ev[N-1:0]); else passed++;
         checks++; if (got_last[k] !== exp_last[k]) $display("FAIL ramp_last[%0d]: got %b exp %b", k, got_last[k], exp_last[k]); else passed++;
         checks++; if (got_cyc[k] != in_cyc[exp_idx[k]] + 1) $display("FAIL ramp_latency[%0d]: got cycle %0d exp %0d", k, got_cyc[k], in_cyc[exp_idx[k]] + 1); else passed++;
      end
      checks++;
      if (fd_cyc.size() != 1 || in_cyc.size() != 16) $display("FAIL ramp_frame_done_count: got %0d exp 1", fd_cyc.size());
      else if (fd_cyc[0] != in_cyc[15] + 1) $display("FAIL ramp_frame_done_cycle: got %0d exp %0d", fd_cyc[0], in_cyc[15] + 1);
      else passed++;
   endtask

   task automatic test_negated();
      int ev;
      sel = 0;
      do_reset();
      fill_ramp(16, 1);
      build_model(4, 4, 1);
      run_stream(16, 0);
      checks++; if (got_data.size() != 4) $display("FAIL neg_count: got %0d exp 4", got_data.size()); else passed++;
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         ev = exp_data[k];
         checks++; if (got_data[k] !== ev[N-1:0]) $display("FAIL neg_data[%0d]: got %h exp %h", k, got_data[k], ev[N-1:0]); else passed++;
      end
   endtask

   task automatic test_backpressure();
      int ev;
      sel = 0;
      do_reset();
      fill_ramp(16, 0);
      build_model(4, 4, 1);
      run_stream(16, 1);
      checks++; if (got_data.size() != 4) $display("FAIL bp_count: got %0d exp 4", got_data.size()); else passed++;
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         ev = exp_data[k];
         checks++; if (got_data[k] !== ev[N-1:0]) $display("FAIL bp_data[%0d]: got %h exp %h", k, got_data[k], ev[N-1:0]); else passed++;
         checks++; if (got_last[k] !== exp_last[k]) $display("FAIL bp_last[%0d]: got %b exp %b", k, got_last[k], exp_last[k]); else passed++;
      end
      checks++; if (viol_stable != 0) $display("FAIL bp_stable: got %0d unstable cycles exp 0", viol_stable); else passed++;
      checks++; if (viol_ready != 0) $display("FAIL bp_in_ready: got %0d bad cycles exp 0", viol_ready); else passed++;
      checks++; if (!saw_stall) $display("FAIL bp_stall_seen: got no in_ready low exp some"); else passed++;
   endtask

   task automatic test_odd_size();
      int ev;
      sel = 1;
      do_reset();
      fill_ramp(25, 0);
      build_model(5, 5, 1);
      run_stream(25, 0);
      checks++; if (got_data.size() != 4) $display("FAIL odd_count: got %0d exp 4", got_data.size()); else passed++;
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         ev = exp_data[k];
         checks++; if (got_data[k] !== ev[N-1:0]) $display("FAIL odd_data[%0d]: got %h exp %h", k, got_data[k], ev[N-1:0]); else passed++;
         checks++; if (got_last[k] !== exp_last[k]) $display("FAIL odd_last[%0d]: got %b exp %b", k, got_last[k], exp_last[k]); else passed++;
      end
      checks++;
      if (fd_cyc.size() != 1 || in_cyc.size() != 25) $display("FAIL odd_frame_done_count: got %0d exp 1", fd_cyc.size());
      else if (fd_cyc[0] != in_cyc[24] + 1) $display("FAIL odd_frame_done_cycle: got %0d exp %0d", fd_cyc[0], in_cyc[24] + 1);
      else passed++;
      sel = 0;
   endtask

   task automatic test_reset_mid_frame();
      int ev;
      sel = 0;
      do_reset();
      fill_ramp(16, 0);
      run_stream(6, 3);
      checks++; if (ov !== 1'b1) $display("FAIL midrst_pending: got out_valid %b exp 1", ov); else passed++;
      @(negedge clk);
      global_rst = 1'b1;
      #1;
      checks++; if (ov !== 1'b0 || od !== '0 || ol !== 1'b0 || fd !== 1'b0)
         $display("FAIL midrst_outputs: got v=%b d=%h l=%b f=%b exp all 0", ov, od, ol, fd); else passed++;
      repeat (2) @(negedge clk);
      global_rst = 1'b0;
      build_model(4, 4, 1);
      run_stream(16, 0);
      checks++; if (got_data.size() != 4) $display("FAIL midrst_count: got %0d exp 4", got_data.size()); else passed++;
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         ev = exp_data[k];
         checks++; if (got_data[k] !== ev[N-1:0]) $display("FAIL midrst_data[%0d]: got %h exp %h", k, got_data[k], ev[N-1:0]); else passed++;
      end
   endtask

   task automatic test_random();
      int ev;
      sel = 0;
      do_reset();
      stim.delete();
      for (int k = 0; k < 48; k++)
         if ($urandom_range(0, 1) == 1) stim.push_back(int'($urandom_range(0, 16777215)) - 8388608);
         else stim.push_back(int'($urandom_range(0, 4)) - 2);
      build_model(4, 4, 3);
      run_stream(48, 2);
      checks++; if (got_data.size() != 12) $display("FAIL rand_count: got %0d exp 12", got_data.size()); else passed++;
      for (int k = 0; k < 12 && k < got_data.size(); k++) begin
         ev = exp_data[k];
         checks++; if (got_data[k] !== ev[N-1:0]) $display("FAIL rand_data[%0d]: got %h exp %h", k, got_data[k], ev[N-1:0]); else passed++;
         checks++; if (got_last[k] !== exp_last[k]) $display("FAIL rand_last[%0d]: got %b exp %b", k, got_last[k], exp_last[k]); else passed++;
      end
      checks++; if (viol_stable != 0) $display("FAIL rand_stable: got %0d exp 0", viol_stable); else passed++;
      checks++; if (viol_ready != 0) $display("FAIL rand_in_ready: got %0d exp 0", viol_ready); else passed++;
      checks++; if (fd_cyc.size() != 3) $display("FAIL rand_frame_done_count: got %0d exp 3", fd_cyc.size()); else passed++;
   endtask

   task automatic test_back_to_back();
      int ev;
      sel = 0;
      do_reset();
      stim.delete();
      for (int k = 0; k < 32; k++) stim.push_back(int'($urandom_range(0, 16777215)) - 8388608);
      build_model(4, 4, 2);
      run_stream(32, 0);
      checks++; if (got_data.size() != 8) $display("FAIL b2b_count: got %0d exp 8", got_data.size()); else passed++;
      checks++; if (in_cyc.size() == 32 && in_cyc[31] - in_cyc[0] != 31)
         $display("FAIL b2b_gapless: got span %0d exp 31", in_cyc[31] - in_cyc[0]); else passed++;
      for (int k = 0; k < 8 && k < got_data.size(); k++) begin
         ev = exp_data[k];
         checks++; if (got_data[k] !== ev[N-1:0]) $display("FAIL b2b_data[%0d]: got %h exp %h", k, got_data[k], ev[N-1:0]); else passed++;
         checks++; if (got_last[k] !== exp_last[k]) $display("FAIL b2b_last[%0d]: got %b exp %b", k, got_last[k], exp_last[k]); else passed++;
      end
      checks++;
      if (fd_cyc.size() != 2 || in_cyc.size() != 32) $display("FAIL b2b_frame_done_count: got %0d exp 2", fd_cyc.size());
      else if (fd_cyc[0] != in_cyc[15] + 1 || fd_cyc[1] != in_cyc[31] + 1)
         $display("FAIL b2b_frame_done_cycle: got %0d,%0d exp %0d,%0d", fd_cyc[0], fd_cyc[1], in_cyc[15] + 1, in_cyc[31] + 1);
      else passed++;
   endtask

   initial begin
      sel = 0;
      global_rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_data = '0;
      test_reset();
      test_ramp();
      test_negated();
      test_backpressure();
      test_odd_size();
      test_reset_mid_frame();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
